// File: rtl/rgb2grey_axis_pipe.sv
// rgb2grey_axis_pipe: two-stage AXI4-Stream RGB to greyscale converter.
// The input stage forms the weighted sum or plain sum of R, G and B. The output stage
// rounds or divides that sum and replicates Y, or passes RGB through in bypass. Each
// beat carries its own latched mode. Line and frame statistics count output handshakes.
module rgb2grey_axis_pipe #(
  parameter int         COMP_W   = 8,
  parameter logic [1:0] MODE_RST = 2'd1,
  parameter int         LCNT_W   = 12,
  parameter int         FCNT_W   = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [1:0]          cfg_mode,
  input  logic                s_axis_tvalid,
  input  logic [3*COMP_W-1:0] s_axis_tdata,
  output logic                s_axis_tready,
  input  logic                s_axis_tuser,
  input  logic                s_axis_tlast,
  output logic                m_axis_tvalid,
  output logic [3*COMP_W-1:0] m_axis_tdata,
  input  logic                m_axis_tready,
  output logic                m_axis_tuser,
  output logic                m_axis_tlast,
  output logic [1:0]          active_mode,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic [LCNT_W-1:0]   line_len
);

  localparam int DW = 3 * COMP_W;
  localparam int PW = COMP_W + 8;  // product / weighted-sum width

  typedef enum logic [1:0] {
    MODE_AVG = 2'd0,
    MODE_601 = 2'd1,
    MODE_709 = 2'd2,
    MODE_BYP = 2'd3
  } mode_e;

  // Mode register and the two pipeline stages
  mode_e             mode_q;
  logic              s1_valid_q, s1_user_q, s1_last_q;
  mode_e             s1_mode_q;
  logic [PW-1:0]     s1_sum_q, s1_sum_d;
  logic [DW-1:0]     s1_pix_q;
  logic              m_valid_q, m_user_q, m_last_q;
  mode_e             m_mode_q;
  logic [DW-1:0]     m_data_q, m_data_d;
  // Statistics
  logic [LCNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc, line_len_q, line_len_d;
  logic [FCNT_W-1:0] frame_q, frame_d;
  mode_e             active_q, active_d;

  logic              en, out_hs;
  mode_e             beat_mode;
  logic [PW-1:0]     r, g, b;
  logic [COMP_W-1:0] y;

  // The whole pipeline advances together whenever the output slot is free or draining
  assign en            = !m_valid_q || m_axis_tready;
  assign out_hs        = m_valid_q && m_axis_tready;
  assign s_axis_tready = en;

  assign r = PW'(s_axis_tdata[DW-1 -: COMP_W]);
  assign g = PW'(s_axis_tdata[2*COMP_W-1 -: COMP_W]);
  assign b = PW'(s_axis_tdata[COMP_W-1:0]);

  // An SOF beat already uses the freshly requested mode; other beats use the latched one
  assign beat_mode = s_axis_tuser ? mode_e'(cfg_mode) : mode_q;

  // Stage 1 arithmetic: plain sum for averaging, weighted sum plus rounding constant for luma
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    s1_sum_d = '0;
    case (beat_mode)
      MODE_AVG: s1_sum_d = r + g + b;
      MODE_601: s1_sum_d = r * PW'(77) + g * PW'(150) + b * PW'(29) + PW'(128);
      MODE_709: s1_sum_d = r * PW'(54) + g * PW'(183) + b * PW'(19) + PW'(128);
      default:  s1_sum_d = '0;
    endcase
  end

  // Stage 2 arithmetic: divide or shift down to Y and replicate it, or pass RGB through
  always_comb begin
    y = '0;
    case (s1_mode_q)
      MODE_AVG: y = COMP_W'(s1_sum_q / PW'(3));
      MODE_601,
      MODE_709: y = s1_sum_q[PW-1:8];
      default:  y = '0;
    endcase
    m_data_d = (s1_mode_q == MODE_BYP) ? s1_pix_q : {3{y}};
  end

  // Mode register and both pipeline stages; all hold together while the output stalls
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: datapath registers are reset too so outputs read zero as soon as reset asserts.
    if (!aresetn) begin
      mode_q     <= mode_e'(MODE_RST);
      s1_valid_q <= 1'b0;
      s1_user_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= mode_e'(MODE_RST);
      s1_sum_q   <= '0;
      s1_pix_q   <= '0;
      m_valid_q  <= 1'b0;
      m_user_q   <= 1'b0;
      m_last_q   <= 1'b0;
      m_mode_q   <= mode_e'(MODE_RST);
      m_data_q   <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      if (s_axis_tvalid && s_axis_tuser) mode_q <= mode_e'(cfg_mode);
      s1_valid_q <= s_axis_tvalid;
      s1_user_q  <= s_axis_tuser;
      s1_last_q  <= s_axis_tlast;
      s1_mode_q  <= beat_mode;
      s1_sum_q   <= s1_sum_d;
      s1_pix_q   <= s_axis_tdata;
      m_valid_q  <= s1_valid_q;
      m_user_q   <= s1_user_q;
      m_last_q   <= s1_last_q;
      m_mode_q   <= s1_mode_q;
      m_data_q   <= m_data_d;
    end
  end

  assign lcnt_inc = (lcnt_q == '1) ? lcnt_q : lcnt_q + LCNT_W'(1);

  // Statistics next state, evaluated only on output handshakes
  always_comb begin
    lcnt_d     = lcnt_q;
    line_len_d = line_len_q;
    frame_d    = frame_q;
    active_d   = active_q;
    if (out_hs) begin
      if (m_user_q) begin
        frame_d  = frame_q + FCNT_W'(1);
        active_d = m_mode_q;
        if (m_last_q) begin
          line_len_d = LCNT_W'(1);
          lcnt_d     = '0;
        end else begin
          lcnt_d     = LCNT_W'(1);
        end
      end else if (m_last_q) begin
        line_len_d = lcnt_inc;
        lcnt_d     = '0;
      end else begin
        lcnt_d     = lcnt_inc;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lcnt_q     <= '0;
      line_len_q <= '0;
      frame_q    <= '0;
      active_q   <= mode_e'(MODE_RST);
    end else begin
      lcnt_q     <= lcnt_d;
      line_len_q <= line_len_d;
      frame_q    <= frame_d;
      active_q   <= active_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign active_mode   = active_q;
  assign frame_cnt     = frame_q;
  assign line_len      = line_len_q;

endmodule

// File: tb/tb_rgb2grey_axis_pipe.sv
// Directed bench for rgb2grey_axis_pipe with default parameters (COMP_W=8, MODE_RST=1).
module tb_rgb2grey_axis_pipe;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  cfg_mode;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
  logic [23:0] s_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
  logic [23:0] m_axis_tdata;
  logic [1:0]  active_mode;
  logic [15:0] frame_cnt;
  logic [11:0] line_len;

  int errors = 0;
  int checks = 0;

  rgb2grey_axis_pipe dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_mode      (cfg_mode),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .active_mode   (active_mode),
    .frame_cnt     (frame_cnt),
    .line_len      (line_len)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Grey pixel {v,v,v}: every mode except bypass maps it to itself
  function automatic logic [23:0] grey(input int i);
    logic [7:0] v;
    v = 8'(16 + i * 5);
    return {v, v, v};
  endfunction

  // One isolated beat with the output always ready: out after 2 edges, stats after the 3rd
  task automatic one_beat(input string tag, input logic [1:0] mode, input logic [23:0] din,
                          input logic u, input logic l, input logic [23:0] exp,
                          input int exp_frame, input int exp_active, input int exp_len);
    cfg_mode      = mode;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = din;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    step();
    check({tag, ".valid"}, 32'(m_axis_tvalid), 32'd1);
    check({tag, ".data"},  32'(m_axis_tdata),  32'(exp));
    check({tag, ".user"},  32'(m_axis_tuser),  32'(u));
    check({tag, ".last"},  32'(m_axis_tlast),  32'(l));
    step();
    check({tag, ".frame"},  32'(frame_cnt),   32'(exp_frame));
    check({tag, ".active"}, 32'(active_mode), 32'(exp_active));
    check({tag, ".len"},    32'(line_len),    32'(exp_len));
  endtask

  initial begin
    int sent, rcvd, stall_left, cyc;
    logic out_hs, in_acc, was_last;
    logic [23:0] exp_d [5];

    aresetn       = 1'b0;
    cfg_mode      = 2'd1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst.valid",  32'(m_axis_tvalid), 32'd0);
    check("rst.tready", 32'(s_axis_tready), 32'd1);
    check("rst.data",   32'(m_axis_tdata),  32'd0);
    check("rst.frame",  32'(frame_cnt),     32'd0);
    check("rst.len",    32'(line_len),      32'd0);
    check("rst.active", 32'(active_mode),   32'd1);
    aresetn = 1'b1;
    step();

    // Single beats in each mode: (77*255+128)>>8=0x4D, 255/3=0x55, (183*255+128)>>8=0xB6
    one_beat("m1_red",    2'd1, 24'hFF0000, 1'b1, 1'b1, 24'h4D4D4D, 1, 1, 1);
    one_beat("m0_red",    2'd0, 24'hFF0000, 1'b1, 1'b0, 24'h555555, 2, 0, 1);
    one_beat("m0_white",  2'd3, 24'hFFFFFF, 1'b0, 1'b0, 24'hFFFFFF, 2, 0, 1);
    one_beat("m0_nochg",  2'd3, 24'hFF0000, 1'b0, 1'b1, 24'h555555, 2, 0, 3);
    one_beat("m2_green",  2'd2, 24'h00FF00, 1'b1, 1'b0, 24'hB6B6B6, 3, 2, 3);
    one_beat("m2_hold",   2'd0, 24'h00FF00, 1'b0, 1'b1, 24'hB6B6B6, 3, 2, 2);
    one_beat("m3_bypass", 2'd3, 24'h123456, 1'b1, 1'b1, 24'h123456, 4, 3, 1);

    // 16 back-to-back beats, two 8-pixel lines, output stalled 5 cycles after beat 3
    sent = 0; rcvd = 0; stall_left = 0; cyc = 0;
    cfg_mode = 2'd1;
    while (rcvd < 16 && cyc < 200) begin
      m_axis_tready = (stall_left == 0);
      s_axis_tvalid = (sent < 16);
      s_axis_tdata  = grey(sent);
      s_axis_tuser  = (sent == 0);
      s_axis_tlast  = (sent % 8 == 7);
      #1;
      out_hs   = m_axis_tvalid && m_axis_tready;
      in_acc   = s_axis_tvalid && s_axis_tready;
      was_last = m_axis_tlast;
      if (out_hs) begin
        check("bb.data", 32'(m_axis_tdata), 32'(grey(rcvd)));
        check("bb.user", 32'(m_axis_tuser), 32'(rcvd == 0));
        check("bb.last", 32'(m_axis_tlast), 32'(rcvd % 8 == 7));
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        check("stall.tready", 32'(s_axis_tready), 32'd0);
        check("stall.data",   32'(m_axis_tdata),  32'(grey(rcvd)));
      end
      step();
      cyc++;
      if (in_acc) sent++;
      if (out_hs) begin
        rcvd++;
        if (was_last) check("bb.line_len", 32'(line_len), 32'd8);
      end
      if (stall_left > 0) stall_left--;
      if (out_hs && rcvd == 4) stall_left = 5;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    check("bb.rcvd",   32'(rcvd),        32'd16);
    check("bb.sent",   32'(sent),        32'd16);
    check("bb.frame",  32'(frame_cnt),   32'd5);
    check("bb.active", 32'(active_mode), 32'd1);
    step();
    check("bb.drained", 32'(m_axis_tvalid), 32'd0);

    // Mid-frame cfg_mode 1->2 is ignored; the next SOF picks up mode 2 ((54*255+128)>>8=0x36)
    exp_d[0] = 24'h4D4D4D; exp_d[1] = 24'h4D4D4D; exp_d[2] = 24'h4D4D4D;
    exp_d[3] = 24'h4D4D4D; exp_d[4] = 24'h363636;
    for (int c = 0; c < 7; c++) begin
      s_axis_tvalid = (c < 5);
      s_axis_tdata  = 24'hFF0000;
      s_axis_tuser  = (c == 0) || (c == 4);
      s_axis_tlast  = (c == 3) || (c == 4);
      cfg_mode      = (c == 0) ? 2'd1 : 2'd2;
      step();
      if (c >= 1 && c <= 5) begin
        check("mid.valid", 32'(m_axis_tvalid), 32'd1);
        check("mid.data",  32'(m_axis_tdata),  32'(exp_d[c-1]));
      end
      if (c == 5) begin
        check("mid.len",    32'(line_len),    32'd4);
        check("mid.active", 32'(active_mode), 32'd1);
        check("mid.frame",  32'(frame_cnt),   32'd6);
      end
    end
    check("nxt.len",    32'(line_len),    32'd1);
    check("nxt.active", 32'(active_mode), 32'd2);
    check("nxt.frame",  32'(frame_cnt),   32'd7);

    // Asynchronous reset with two beats in flight
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 24'h102030;
    step();
    s_axis_tdata  = 24'h405060;
    step();
    s_axis_tvalid = 1'b0;
    check("fly.valid", 32'(m_axis_tvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("ares.valid",  32'(m_axis_tvalid), 32'd0);
    check("ares.data",   32'(m_axis_tdata),  32'd0);
    check("ares.frame",  32'(frame_cnt),     32'd0);
    check("ares.len",    32'(line_len),      32'd0);
    check("ares.active", 32'(active_mode),   32'd1);
    #2 aresetn = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) step();
    check("rel.valid", 32'(m_axis_tvalid), 32'd0);
    one_beat("restart", 2'd2, 24'h00FF00, 1'b1, 1'b1, 24'hB6B6B6, 1, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
